// File: rtl/sample_sequencer_if.sv
// Signal bundle between the heart-rate sequencer and the SPI, filter, peak finder and DAC blocks.
interface sample_sequencer_if;
    logic       sck;
    logic       dac_done;
    logic       sample_strobe;
    logic       filt_en;
    logic       peak_en;
    logic       dac_start;
    logic       window_tick;
    logic       busy;
    logic       resync;
    logic [7:0] overrun_cnt;

    // The sequencer drives the enables; the datapath blocks drive sck and dac_done.
    modport master (
        input  sck, dac_done,
        output sample_strobe, filt_en, peak_en, dac_start, window_tick, busy, resync, overrun_cnt
    );
    modport slave (
        output sck, dac_done,
        input  sample_strobe, filt_en, peak_en, dac_start, window_tick, busy, resync, overrun_cnt
    );
endinterface

// File: rtl/sample_sequencer.sv
// Central sequencer for the heart-rate datapath: frames synchronised sck edges into samples
// and issues ordered filter/peak/DAC enables plus the BPM-window tick.
module sample_sequencer #(
    parameter int unsigned FRAME_BITS     = 16,
    parameter int unsigned TIMEOUT_CYC    = 1024,
    parameter int unsigned FILT_LAT       = 2,
    parameter int unsigned WINDOW_SAMPLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    sample_sequencer_if.master bus
);
    localparam int unsigned BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned LAT_W  = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
    localparam int unsigned WIN_W  = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;

    typedef enum logic [1:0] {IDLE, FILT, DAC_WAIT} state_t;

    state_t             state, state_nxt;
    logic [2:0]         sck_sync;
    logic [2:0]         sck_vld;
    logic               sck_rise, frame_done, timeout;
    logic [BIT_W-1:0]   bit_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [LAT_W-1:0]   filt_cnt, filt_cnt_nxt;
    logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
    logic               pending, pending_nxt;
    logic [7:0]         overrun_q, overrun_nxt;
    logic               strobe_q, strobe_nxt;
    logic               peak_q, peak_nxt;
    logic               tick_q, tick_nxt;
    logic               busy_q, resync_q;

    // 2-flop synchroniser plus edge history; sck_vld masks edges until real samples fill the chain,
    // so an sck held high across reset does not look like a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= '0;
            sck_vld  <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], bus.sck};
            sck_vld  <= {sck_vld[1:0], 1'b1};
        end
    end

    assign sck_rise   = sck_sync[1] & ~sck_sync[2] & sck_vld[2];
    assign frame_done = sck_rise && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign timeout    = !sck_rise && (idle_cnt == IDLE_W'(TIMEOUT_CYC)) && (bit_cnt != '0);

    // Bit framing and idle timeout resync.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= timeout;
            if (sck_rise) begin
                idle_cnt <= '0;
                bit_cnt  <= frame_done ? '0 : bit_cnt + 1'b1;
            end else begin
                if (idle_cnt != IDLE_W'(TIMEOUT_CYC))
                    idle_cnt <= idle_cnt + 1'b1;
                if (timeout)
                    bit_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state, pulse generation, one-deep frame buffer and window counting.
    always_comb begin
        state_nxt    = state;
        filt_cnt_nxt = filt_cnt;
        pending_nxt  = pending;
        win_cnt_nxt  = win_cnt;
        overrun_nxt  = overrun_q;
        strobe_nxt   = 1'b0;
        peak_nxt     = 1'b0;
        tick_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_done || pending) begin
                    state_nxt    = FILT;
                    strobe_nxt   = 1'b1;
                    filt_cnt_nxt = '0;
                    pending_nxt  = pending && frame_done;
                    if (win_cnt == WIN_W'(WINDOW_SAMPLES - 1)) begin
                        win_cnt_nxt = '0;
                        tick_nxt    = 1'b1;
                    end else begin
                        win_cnt_nxt = win_cnt + 1'b1;
                    end
                end
            end
            FILT: begin
                if (filt_cnt == LAT_W'(FILT_LAT - 1)) begin
                    state_nxt = DAC_WAIT;
                    peak_nxt  = 1'b1;
                end else begin
                    filt_cnt_nxt = filt_cnt + 1'b1;
                end
            end
            DAC_WAIT: begin
                // A dac_done level left over from the previous word must not end this one.
                if (bus.dac_done && !peak_q)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && frame_done) begin
            if (!pending)
                pending_nxt = 1'b1;
            else if (overrun_q != 8'hFF)
                overrun_nxt = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt  <= '0;
            win_cnt   <= '0;
            pending   <= 1'b0;
            overrun_q <= '0;
            strobe_q  <= 1'b0;
            peak_q    <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            filt_cnt  <= filt_cnt_nxt;
            win_cnt   <= win_cnt_nxt;
            pending   <= pending_nxt;
            overrun_q <= overrun_nxt;
            strobe_q  <= strobe_nxt;
            peak_q    <= peak_nxt;
            tick_q    <= tick_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.sample_strobe = strobe_q;
    assign bus.filt_en       = strobe_q;
    assign bus.peak_en       = peak_q;
    assign bus.dac_start     = peak_q;
    assign bus.window_tick   = tick_q;
    assign bus.busy          = busy_q;
    assign bus.resync        = resync_q;
    assign bus.overrun_cnt   = overrun_q;
endmodule
